// File: rtl/lift_car_if.sv
// Command/status bundle between a lift controller and the lift car model.
// out_floor_onehot exists only when LIFT_CAR_POS_ONEHOT_EN is defined.
interface lift_car_if #(
    parameter int NUM_FLOORS = 11
);
    logic                  in_up_direction;
    logic                  in_down_direction;
    logic                  in_door_opening;
    logic                  in_door_closing;
    logic                  in_door_obstacle;
    logic [3:0]            out_floor;
    logic                  out_floor_arrive;
    logic                  out_moving;
    logic                  out_door_open;
    logic                  out_door_closed;
    logic                  out_fault;
`ifdef LIFT_CAR_POS_ONEHOT_EN
    logic [NUM_FLOORS-1:0] out_floor_onehot;
`endif

    modport master (
        output in_up_direction, in_down_direction, in_door_opening,
               in_door_closing, in_door_obstacle,
        input  out_floor, out_floor_arrive, out_moving, out_door_open,
               out_door_closed, out_fault
`ifdef LIFT_CAR_POS_ONEHOT_EN
        , input out_floor_onehot
`endif
    );

    modport slave (
        input  in_up_direction, in_down_direction, in_door_opening,
               in_door_closing, in_door_obstacle,
        output out_floor, out_floor_arrive, out_moving, out_door_open,
               out_door_closed, out_fault
`ifdef LIFT_CAR_POS_ONEHOT_EN
        , output out_floor_onehot
`endif
    );
endinterface

// File: rtl/lift_car_model.sv
// Cycle-accurate lift car / shaft responder: motion and door strokes with sticky fault.
// Optional LIFT_CAR_POS_ONEHOT_EN adds a registered one-hot floor output.
module lift_car_model #(
    parameter int NUM_FLOORS          = 11,
    parameter int FLOOR_TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES         = 3
) (
    input  logic        clk,
    input  logic        rst,
    lift_car_if.slave   bus
);
    localparam int CNT_MAX = (FLOOR_TRAVEL_CYCLES > DOOR_CYCLES) ? FLOOR_TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] TRAVEL_LAST = CW'(FLOOR_TRAVEL_CYCLES - 1);
    localparam logic [CW-1:0] DOOR_LAST   = CW'(DOOR_CYCLES - 1);
    localparam logic [3:0]    TOP_FLOOR   = 4'(NUM_FLOORS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_MOVE_UP, S_MOVE_DN, S_DOOR_OPENING, S_DOOR_OPEN, S_DOOR_CLOSING
    } state_t;

    state_t          r_state,       w_state;
    logic [CW-1:0]   r_cnt,         w_cnt;
    logic [3:0]      r_floor,       w_floor;
    logic            r_arrive,      w_arrive;
    logic            r_moving,      w_moving;
    logic            r_door_open,   w_door_open;
    logic            r_door_closed, w_door_closed;
    logic            r_fault,       w_fault;
    logic            w_up, w_dn, w_op, w_cl, w_ob;
    logic            w_dir_up, w_same, w_opp;
    logic [3:0]      w_floor_step, w_end_floor;

    assign w_up = bus.in_up_direction;
    assign w_dn = bus.in_down_direction;
    assign w_op = bus.in_door_opening;
    assign w_cl = bus.in_door_closing;
    assign w_ob = bus.in_door_obstacle;

    assign w_dir_up     = (r_state == S_MOVE_UP);
    assign w_same       = w_dir_up ? w_up : w_dn;
    assign w_opp        = w_dir_up ? w_dn : w_up;
    assign w_floor_step = w_dir_up ? (r_floor + 4'd1) : (r_floor - 4'd1);
    assign w_end_floor  = w_dir_up ? TOP_FLOOR : 4'd0;

    // Next-state and next-output computation for the car/door FSM
    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_floor       = r_floor;
        w_arrive      = 1'b0;
        w_moving      = r_moving;
        w_door_open   = r_door_open;
        w_door_closed = r_door_closed;
        w_fault       = r_fault;
        case (r_state)
            S_IDLE: begin
                if ((w_up && w_dn) || (w_op && w_cl)) begin
                    w_fault = 1'b1;
                end else if (w_up && (r_floor != TOP_FLOOR)) begin
                    w_state = S_MOVE_UP;
                    w_cnt   = '0;
                end else if (w_dn && (r_floor != 4'd0)) begin
                    w_state = S_MOVE_DN;
                    w_cnt   = '0;
                end else if (w_op) begin
                    w_state       = S_DOOR_OPENING;
                    w_cnt         = '0;
                    w_door_closed = 1'b0;
                end else if (w_up || w_dn) begin
                    w_fault = 1'b1;
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_MOVE_UP, S_MOVE_DN: begin
                if (w_opp || w_op || w_cl) begin
                    w_fault = 1'b1;
                end else begin
                    w_fault = r_fault;
                end
                // The first cycle after leaving IDLE only raises out_moving; the stroke count starts after it
                if (!r_moving) begin
                    w_moving = 1'b1;
                end else if (r_cnt == TRAVEL_LAST) begin
                    w_floor  = w_floor_step;
                    w_arrive = 1'b1;
                    w_cnt    = '0;
                    if (w_same && (w_floor_step != w_end_floor)) begin
                        w_moving = 1'b1;
                    end else begin
                        w_state  = S_IDLE;
                        w_moving = 1'b0;
                    end
                end else begin
                    w_cnt = r_cnt + CW'(1'b1);
                end
            end
            S_DOOR_OPENING: begin
                if (w_op && w_cl) begin
                    w_fault = 1'b1;
                end else if (r_cnt == DOOR_LAST) begin
                    w_state     = S_DOOR_OPEN;
                    w_door_open = 1'b1;
                    w_cnt       = '0;
                end else begin
                    w_cnt = r_cnt + CW'(1'b1);
                end
            end
            S_DOOR_OPEN: begin
                if (w_op && w_cl) begin
                    w_fault = 1'b1;
                end else if (w_cl) begin
                    w_state     = S_DOOR_CLOSING;
                    w_door_open = 1'b0;
                    w_cnt       = '0;
                end else begin
                    w_state = S_DOOR_OPEN;
                end
                if (w_up || w_dn) begin
                    w_fault = 1'b1;
                end else begin
                    w_moving = 1'b0;
                end
            end
            S_DOOR_CLOSING: begin
                if (w_op && w_cl) begin
                    w_fault = 1'b1;
                end else if (w_ob) begin
                    w_state = S_DOOR_OPENING;
                    w_cnt   = '0;
                end else if (r_cnt == DOOR_LAST) begin
                    w_state       = S_IDLE;
                    w_door_closed = 1'b1;
                    w_cnt         = '0;
                end else begin
                    w_cnt = r_cnt + CW'(1'b1);
                end
            end
            default: begin
                w_state       = S_IDLE;
                w_cnt         = '0;
                w_moving      = 1'b0;
                w_door_open   = 1'b0;
                w_door_closed = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_floor       <= 4'd0;
            r_arrive      <= 1'b0;
            r_moving      <= 1'b0;
            r_door_open   <= 1'b0;
            r_door_closed <= 1'b1;
            r_fault       <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_floor       <= w_floor;
            r_arrive      <= w_arrive;
            r_moving      <= w_moving;
            r_door_open   <= w_door_open;
            r_door_closed <= w_door_closed;
            r_fault       <= w_fault;
        end
    end

    assign bus.out_floor        = r_floor;
    assign bus.out_floor_arrive = r_arrive;
    assign bus.out_moving       = r_moving;
    assign bus.out_door_open    = r_door_open;
    assign bus.out_door_closed  = r_door_closed;
    assign bus.out_fault        = r_fault;

`ifdef LIFT_CAR_POS_ONEHOT_EN
    logic [NUM_FLOORS-1:0] r_floor_onehot;

    // One-hot floor register tracking w_floor on the same edge as r_floor
    always_ff @(posedge clk) begin
        if (rst) begin
            r_floor_onehot <= {{(NUM_FLOORS-1){1'b0}}, 1'b1};
        end else begin
            r_floor_onehot <= {{(NUM_FLOORS-1){1'b0}}, 1'b1} << w_floor;
        end
    end

    assign bus.out_floor_onehot = r_floor_onehot;
`endif
endmodule

// File: tb/tb_lift_car_model.sv
// Scoreboard bench for lift_car_model: directed scenarios then randomized commands,
// checked every cycle against a countdown-based behavioural model.
module tb_lift_car_model;
    localparam int N = 11;
    localparam int F = 4;
    localparam int D = 3;

    localparam int M_IDLE = 0, M_TRAVEL = 1, M_OPENING = 2, M_OPEN = 3, M_CLOSING = 4;

    typedef struct packed {
        logic [3:0]   floor;
        logic         arrive;
        logic         moving;
        logic         dopen;
        logic         dclosed;
        logic         fault;
        logic [N-1:0] onehot;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    lift_car_if #(.NUM_FLOORS(N)) bus();

    lift_car_model #(.NUM_FLOORS(N), .FLOOR_TRAVEL_CYCLES(F), .DOOR_CYCLES(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: mode, travel direction and a countdown of remaining cycles
    int m_mode  = M_IDLE;
    int m_dir   = 0;
    int m_rem   = 0;
    int m_floor = 0;
    bit m_fault = 1'b0;
    bit m_arrive = 1'b0;

    function automatic void model_step(input bit up, dn, op, cl, ob, rs);
        bit want, against;
        m_arrive = 1'b0;
        if (rs) begin
            m_mode = M_IDLE; m_dir = 0; m_rem = 0; m_floor = 0; m_fault = 1'b0;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if ((up && dn) || (op && cl)) m_fault = 1'b1;
                else if (up && m_floor < N - 1) begin m_mode = M_TRAVEL; m_dir = 1;  m_rem = F + 1; end
                else if (dn && m_floor > 0)     begin m_mode = M_TRAVEL; m_dir = -1; m_rem = F + 1; end
                else if (op) begin m_mode = M_OPENING; m_rem = D; end
                else if (up || dn) m_fault = 1'b1;
            end
            M_TRAVEL: begin
                want    = (m_dir > 0) ? up : dn;
                against = (m_dir > 0) ? dn : up;
                if (against || op || cl) m_fault = 1'b1;
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_floor  = m_floor + m_dir;
                    m_arrive = 1'b1;
                    if (want && (m_floor + m_dir >= 0) && (m_floor + m_dir <= N - 1)) m_rem = F;
                    else m_mode = M_IDLE;
                end
            end
            M_OPENING: begin
                if (op && cl) m_fault = 1'b1;
                else begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) m_mode = M_OPEN;
                end
            end
            M_OPEN: begin
                if (op && cl) m_fault = 1'b1;
                else if (cl) begin m_mode = M_CLOSING; m_rem = D; end
                if (up || dn) m_fault = 1'b1;
            end
            M_CLOSING: begin
                if (op && cl) m_fault = 1'b1;
                else if (ob) begin m_mode = M_OPENING; m_rem = D; end
                else begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) m_mode = M_IDLE;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.floor   = 4'(m_floor);
        e.arrive  = m_arrive;
        e.moving  = (m_mode == M_TRAVEL) && (m_rem <= F);
        e.dopen   = (m_mode == M_OPEN);
        e.dclosed = (m_mode == M_IDLE) || (m_mode == M_TRAVEL);
        e.fault   = m_fault;
        e.onehot  = {{(N-1){1'b0}}, 1'b1} << m_floor;
        return e;
    endfunction

    task automatic step(input bit up, dn, op, cl, ob, rs);
        bus.in_up_direction   = up;
        bus.in_down_direction = dn;
        bus.in_door_opening   = op;
        bus.in_door_closing   = cl;
        bus.in_door_obstacle  = ob;
        rst                   = rs;
        @(posedge clk);
        model_step(up, dn, op, cl, ob, rs);
        exp_q.push_back(snapshot());
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: pops one expectation per presented output cycle and compares away from the edge
    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got.floor   = bus.out_floor;
            got.arrive  = bus.out_floor_arrive;
            got.moving  = bus.out_moving;
            got.dopen   = bus.out_door_open;
            got.dclosed = bus.out_door_closed;
            got.fault   = bus.out_fault;
`ifdef LIFT_CAR_POS_ONEHOT_EN
            got.onehot  = bus.out_floor_onehot;
`else
            got.onehot  = e.onehot;
`endif
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL outputs @%0t: got floor=%0d arr=%b mov=%b open=%b closed=%b fault=%b oh=%b, expected floor=%0d arr=%b mov=%b open=%b closed=%b fault=%b oh=%b",
                         $time, got.floor, got.arrive, got.moving, got.dopen, got.dclosed, got.fault, got.onehot,
                         e.floor, e.arrive, e.moving, e.dopen, e.dclosed, e.fault, e.onehot);
            end
        end
    end

    initial begin
        int hold;
        int sel;
        bit up, dn, op, cl, ob, rs;
        bus.in_up_direction   = 1'b0;
        bus.in_down_direction = 1'b0;
        bus.in_door_opening   = 1'b0;
        bus.in_door_closing   = 1'b0;
        bus.in_door_obstacle  = 1'b0;

        // Reset then idle
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(5);

        // Hold up through floors 1..3, drop it so the car completes floor 4 and stops
        for (int i = 0; i < 40 && m_floor != 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(10);

        // Door open, close with obstacle on the second closing cycle, reopen
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(5);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(5);

        // Conflicting motion commands in IDLE: sticky fault until reset
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Down at floor 0 faults; then go to floor 2, short down pulse, reset mid-travel
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40 && m_floor != 1; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(8);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(10);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Run to the top floor holding up, then keep up held at the top
        for (int i = 0; i < 100 && m_floor != N - 1; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized command runs with occasional reset
        for (int blk = 0; blk < 600; blk++) begin
            sel  = $urandom_range(0, 15);
            hold = $urandom_range(1, 8);
            up = (sel <= 4) || (sel == 12);
            dn = (sel >= 5 && sel <= 7) || (sel == 12);
            op = (sel == 8) || (sel == 9) || (sel == 14);
            cl = (sel == 10) || (sel == 11) || (sel == 14);
            ob = (sel == 13);
            rs = ($urandom_range(0, 39) == 0);
            step(up, dn, op, cl, ob, rs);
            for (int k = 1; k < hold; k++) step(up, dn, op, cl, ob, 1'b0);
        end
        idle(2);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
